// File: rtl/lcd_pkg.sv
// Types and default geometry shared by the lcd panel controller and its pixel feed.
package lcd_pkg;

    localparam int LCD_H_ACT = 320;
    localparam int LCD_V_ACT = 240;
    localparam int CNT_W     = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } feed_st_t;

    // Bar 0 is white: the bar index is inverted before picking the primaries.
    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        rgb444_t    c;
        logic [2:0] sel;
        sel = ~idx;
        c.r = {4{sel[2]}};
        c.g = {4{sel[1]}};
        c.b = {4{sel[0]}};
        return c;
    endfunction

endpackage

// File: rtl/lcd_feed_fifo.sv
// Synchronous pixel FIFO with flush; pointers carry a wrap bit to tell full from empty.
module lcd_feed_fifo
    import lcd_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    push,
    input  logic    pop,
    input  rgb444_t wdata,
    output rgb444_t rdata,
    output logic    full,
    output logic    empty
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rgb444_t     mem [2**AW];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_feed.sv
// Crops a window from the RGB444 video stream and feeds it to lcd through a FIFO.
// Optional colour-bar generator: define LCD_FEED_TESTPAT_EN.
module lcd_feed
    import lcd_pkg::*;
#(
    parameter int H_ACT   = LCD_H_ACT,
    parameter int V_ACT   = LCD_V_ACT,
    parameter int H_OFF   = 0,
    parameter int V_OFF   = 0,
    parameter int FIFO_AW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vid_vs,
    input  logic       vid_hs,
    input  logic       vid_de,
    input  logic [3:0] vid_r,
    input  logic [3:0] vid_g,
    input  logic [3:0] vid_b,
    input  logic       tpat,
    output logic       sof,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       pix_vld,
    input  logic       pix_req,
    output logic       ovf,
    output logic       udf
);

    localparam int TOTAL = H_ACT * V_ACT;
    localparam int PW    = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0] X_LO   = CNT_W'(H_OFF);
    localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(V_OFF);
    localparam logic [CNT_W-1:0] X_SPAN = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] Y_SPAN = CNT_W'(V_ACT);
    localparam logic [PW-1:0]    PIX_TOTAL = PW'(TOTAL);

    feed_st_t         state;
    feed_st_t         state_nxt;
    logic             vs_q, hs_q, vs_rise, hs_rise;
    logic [CNT_W-1:0] xcnt, ycnt, x_rel, y_rel;
    logic [PW-1:0]    pcnt;
    logic             in_win, capture, restart, accept;
    logic             push_q, fifo_pop, fifo_full, fifo_empty;
    rgb444_t          pix_in, pix_q, head, hold, pix_out;

    // Sync history is not reset so a sync held high across reset is not taken as a new edge.
    always_ff @(posedge clk) begin
        vs_q <= vid_vs;
        hs_q <= vid_hs;
    end

    assign vs_rise = vid_vs & ~vs_q;
    assign hs_rise = vid_hs & ~hs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xcnt <= '0;
            ycnt <= '0;
        end else begin
            if (hs_rise)                  xcnt <= '0;
            else if (vid_de && xcnt != '1) xcnt <= xcnt + 1'b1;
            if (vs_rise)                  ycnt <= '0;
            else if (hs_rise && ycnt != '1) ycnt <= ycnt + 1'b1;
        end
    end

    // Offsets below the window wrap to large values, so one compare per axis suffices.
    assign x_rel  = xcnt - X_LO;
    assign y_rel  = ycnt - Y_LO;
    assign in_win = vid_de && (x_rel < X_SPAN) && (y_rel < Y_SPAN);
    assign accept = capture && in_win && (pcnt != PIX_TOTAL);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  if (vs_rise) state_nxt = ACTIVE;
                     else if (pcnt == PIX_TOTAL) state_nxt = DONE;
            DONE:    if (vs_rise) state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        restart = 1'b0;
        case (state)
            ACTIVE: begin
                capture = 1'b1;
                restart = vs_rise;
            end
            DONE:    restart = vs_rise;
            default: ;
        endcase
    end

`ifdef LCD_FEED_TESTPAT_EN
    localparam int BAR_W = (H_ACT >= 8) ? H_ACT / 8 : 1;
    always_comb begin
        pix_in = '{r: vid_r, g: vid_g, b: vid_b};
        if (tpat) pix_in = bar_colour(3'(x_rel / CNT_W'(BAR_W)));
    end
`else
    logic tpat_unused;
    assign tpat_unused = tpat;
    assign pix_in      = '{r: vid_r, g: vid_g, b: vid_b};
`endif

    // pcnt counts accepted pixels, including ones later dropped, so frame length is fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            push_q <= 1'b0;
            pix_q  <= '0;
            sof    <= 1'b0;
        end else begin
            if (vs_rise)     pcnt <= '0;
            else if (accept) pcnt <= pcnt + 1'b1;
            push_q <= accept;
            if (accept) pix_q <= pix_in;
            sof <= vs_rise;
        end
    end

    assign fifo_pop = pix_req & ~fifo_empty;

    lcd_feed_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (restart),
        .push  (push_q),
        .pop   (fifo_pop),
        .wdata (pix_q),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push_q && fifo_full && !fifo_pop) ovf <= 1'b1;
            if (pix_req && fifo_empty)            udf <= 1'b1;
        end
    end

    // Remember the last head so r/g/b stay steady while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst)              hold <= '0;
        else if (!fifo_empty) hold <= head;
    end

    assign pix_out = fifo_empty ? hold : head;
    assign pix_vld = ~fifo_empty;
    assign r       = pix_out.r;
    assign g       = pix_out.g;
    assign b       = pix_out.b;

endmodule

// File: tb/tb_lcd_feed.sv
// Randomized bench for lcd_feed against a queue-based model of the crop window and FIFO.
module tb_lcd_feed;

    localparam int H_ACT    = 8;
    localparam int V_ACT    = 6;
    localparam int H_OFF    = 2;
    localparam int V_OFF    = 1;
    localparam int FIFO_AW  = 5;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int TOTAL    = H_ACT * V_ACT;
    localparam int LINE_PIX = 12;
    localparam int LINES    = 8;
    localparam int BAR_W    = (H_ACT >= 8) ? H_ACT / 8 : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vid_vs = 1'b0, vid_hs = 1'b0, vid_de = 1'b0;
    logic [3:0] vid_r = '0, vid_g = '0, vid_b = '0;
    logic       tpat = 1'b0, pix_req = 1'b0;
    logic       sof, pix_vld, ovf, udf;
    logic [3:0] r, g, b;

    always #5 clk = ~clk;

    lcd_feed #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .H_OFF   (H_OFF),
        .V_OFF   (V_OFF),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vid_vs  (vid_vs),
        .vid_hs  (vid_hs),
        .vid_de  (vid_de),
        .vid_r   (vid_r),
        .vid_g   (vid_g),
        .vid_b   (vid_b),
        .tpat    (tpat),
        .sof     (sof),
        .r       (r),
        .g       (g),
        .b       (b),
        .pix_vld (pix_vld),
        .pix_req (pix_req),
        .ovf     (ovf),
        .udf     (udf)
    );

    int          checks = 0;
    int          failures = 0;
    int          dut_pops = 0;
    int          req_mode = 0;
    logic [11:0] mq[$];
    bit          stage_v = 1'b0;
    logic [11:0] stage_pix = '0;
    bit          started = 1'b0;
    int          taken = 0;
    bit          m_ovf = 1'b0, m_udf = 1'b0, m_sof = 1'b0;
    logic [11:0] shown = '0;
    bit          prev_vs = 1'b0;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input bit i_rst, input bit vs, input bit hs, input bit de,
                                 input bit win, input int px,
                                 input logic [3:0] pr, input logic [3:0] pg, input logic [3:0] pb);
        bit          req, tp, vs_rise, restart, acc;
        logic [11:0] pix;
        case (req_mode)
            0:       req = 1'b0;
            1:       req = 1'b1;
            2:       req = (mq.size() >= DEPTH);
            default: req = ($urandom_range(0, 3) != 0);
        endcase
        tp = 1'($urandom_range(0, 1));
        rst = i_rst; vid_vs = vs; vid_hs = hs; vid_de = de;
        vid_r = pr; vid_g = pg; vid_b = pb; pix_req = req; tpat = tp;

        pix = {pr, pg, pb};
`ifdef LCD_FEED_TESTPAT_EN
        if (tp) begin
            logic [2:0] bidx;
            bidx = 3'((px - H_OFF) / BAR_W);
            bidx = ~bidx;
            pix = {{4{bidx[2]}}, {4{bidx[1]}}, {4{bidx[0]}}};
        end
`endif
        vs_rise = vs && !prev_vs;
        prev_vs = vs;
        restart = vs_rise && started;
        if (!i_rst && !restart && req && pix_vld) dut_pops++;

        if (i_rst) begin
            mq.delete();
            stage_v = 1'b0; started = 1'b0; taken = 0;
            m_ovf = 1'b0; m_udf = 1'b0; m_sof = 1'b0; shown = '0;
        end else begin
            if (restart) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (req && mq.size() == 0) m_udf = 1'b1;
                if (req && mq.size() > 0) void'(mq.pop_front());
                if (stage_v) begin
                    if (mq.size() < DEPTH) mq.push_back(stage_pix);
                    else                   m_ovf = 1'b1;
                end
            end
            acc = started && de && win && (taken < TOTAL);
            stage_v = acc;
            if (acc) begin
                stage_pix = pix;
                taken++;
            end
            if (vs_rise) begin
                started = 1'b1;
                taken = 0;
            end
            m_sof = vs_rise;
            if (mq.size() > 0) shown = mq[0];
        end

        @(posedge clk);
        #1;
        checkOutput("pix_vld", int'(pix_vld), int'(mq.size() > 0));
        checkOutput("rgb", int'({r, g, b}), int'(shown));
        checkOutput("ovf", int'(ovf), int'(m_ovf));
        checkOutput("udf", int'(udf), int'(m_udf));
        checkOutput("sof", int'(sof), int'(m_sof));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    // A frame: vs pulse, line 0 before the first hs, then LINES numbered lines of LINE_PIX strobes.
    task automatic sendFrame(input bit ramp, input int rst_line);
        bit         win;
        logic [3:0] pr;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
        idle(2);
        for (int ln = 0; ln <= LINES; ln++) begin
            if (ln == rst_line) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
            if (ln > 0) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
                idle(1);
            end
            for (int px = 0; px < LINE_PIX; px++) begin
                win = (ln >= V_OFF) && (ln < V_OFF + V_ACT) && (px >= H_OFF) && (px < H_OFF + H_ACT);
                pr  = ramp ? 4'(px) : 4'($urandom);
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, win, px, pr, 4'($urandom), 4'($urandom));
            end
            idle(2);
        end
    endtask

    initial begin
        req_mode = 0;
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
        req_mode = 3;
        idle(15);

        req_mode = 1;
        dut_pops = 0;
        sendFrame(1'b1, -1);
        idle(10);
        checkOutput("frame1_delivered", dut_pops, TOTAL);

        req_mode = 0;
        sendFrame(1'b0, -1);
        checkOutput("fill_ovf", int'(ovf), 1);
        checkOutput("fill_vld", int'(pix_vld), 1);
        req_mode = 1;
        dut_pops = 0;
        idle(40);
        checkOutput("drain_count", dut_pops, DEPTH);
        checkOutput("drain_udf", int'(udf), 1);

        req_mode = 2;
        sendFrame(1'b0, -1);
        checkOutput("full_pushpop_ovf", int'(ovf), 0);
        checkOutput("full_pushpop_vld", int'(pix_vld), 1);
        req_mode = 1;
        idle(40);

        req_mode = 0;
        sendFrame(1'b0, 3);
        checkOutput("post_reset_vld", int'(pix_vld), 0);
        checkOutput("post_reset_sof", int'(sof), 0);

        req_mode = 3;
        sendFrame(1'b0, -1);
        sendFrame(1'b1, -1);
        req_mode = 1;
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
